pipeline_monitor: RTL
=====================

PIPELINE_MONITOR -- requirements
Module: pipeline_monitor

Interface
REQ-001 Parameter CNT_W, default 32: width of every counter output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; arms a run from IDLE.
REQ-005 clear  input  1  one-cycle pulse; returns HALT/TIMEOUT to IDLE.
REQ-006 max_cycles  input  CNT_W  timeout limit, sampled on start; 0 disables timeout.
REQ-007 ex0_valid, ex1_valid  input  1 each  slot 0 / slot 1 execute-stage instruction valid.
REQ-008 ex0_instr, ex1_instr  input  32 each  execute-stage instruction words; slot 0 is older.
REQ-009 redirect0, redirect1  input  1 each  branch-taken OR jump-taken per slot.
REQ-010 stall, bubble  input  1 each  pipeline stall flag and execute-bubble flag.
REQ-011 state  output  2  FSM state encoding from the shared package.
REQ-012 cycle_cnt, retired_cnt, redirect_cnt  output  CNT_W each  run statistics.
REQ-013 halted, timed_out  output  1 each  sticky terminal status.
REQ-014 done  output  1  one-cycle pulse on entry to HALT or TIMEOUT.
REQ-015 halt_cause  output  2  0 none, 1 ECALL (0x00000073), 2 EBREAK (0x00100073).
REQ-016 halt_slot  output  1  slot holding the halting instruction.

Function
REQ-017 FSM states IDLE, RUN, HALT, TIMEOUT; IDLE->RUN on start; RUN->HALT on a valid ECALL/EBREAK in either slot; RUN->TIMEOUT when cycle_cnt after increment equals latched max_cycles (nonzero); HALT/TIMEOUT->IDLE on clear.
REQ-018 start in IDLE zeroes all counters and status in the same edge; start outside IDLE is ignored; clear outside HALT/TIMEOUT is ignored.
REQ-019 cycle_cnt increments by 1 every RUN cycle, including the terminating cycle.
REQ-020 retired_cnt adds count of valid slots per RUN cycle (0, 1 or 2); a halting instruction counts as retired.
REQ-021 If slot 0 halts, slot 1 in the same cycle is not counted and its redirect ignored; halt_slot=0.
REQ-022 If only slot 1 halts, slot 0 counted normally; halt_slot=1.
REQ-023 redirect_cnt adds count of (valid AND redirect) per slot per RUN cycle, subject to REQ-021.
REQ-024 Halt and timeout in the same cycle: HALT wins, timed_out stays 0.
REQ-025 All counters saturate at all-ones; no wrap.
REQ-026 Counters frozen outside RUN; inputs ignored outside RUN.
REQ-027 Outputs are registered; statistics reflect a RUN cycle one edge later.

Reset
REQ-028 rst_n low: state=IDLE, all counters 0, halted=0, timed_out=0, done=0, halt_cause=0, halt_slot=0, latched max_cycles=0, immediately and asynchronously.
REQ-029 Reset asserted mid-run aborts without done pulse; next run requires start.

Configuration
REQ-030 Macro PIPELINE_MONITOR_STALL_STATS_EN defined: extra outputs stall_cnt and bubble_cnt (CNT_W each), incremented per RUN cycle with stall / bubble high, saturating, same reset/clear/start rules.
REQ-031 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-032 rv32i_pkg holds the state enum, halt_cause enum, and ECALL/EBREAK instruction constants.
REQ-033 One sub-module, sat_counter (parameter width; inputs clr, inc amount 0..2), instantiated per counter.

Verification
REQ-034 start, max_cycles=100, 10 cycles both slots valid NOPs, then slot 0 = 0x00000073 -> HALT, retired_cnt=21, cycle_cnt=11, halt_cause=1, halt_slot=0, done pulse once.
REQ-035 slot 0 valid NOP, slot 1 = 0x00100073 in first RUN cycle -> retired_cnt=2, halt_cause=2, halt_slot=1.
REQ-036 max_cycles=5, no halts -> TIMEOUT after 5 RUN cycles, timed_out=1, cycle_cnt=5; EBREAK on cycle 5 instead -> HALT, timed_out=0.
REQ-037 slot 0 ECALL with slot 1 valid and redirect1=1 -> slot 1 uncounted, redirect_cnt unchanged.
REQ-038 CNT_W=4, 20 RUN cycles both valid -> retired_cnt=15, cycle_cnt=15, no wrap.
REQ-039 rst_n low mid-RUN -> all outputs zero at once, no done; with macro defined, stall high 3 cycles -> stall_cnt=3.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types for the pipeline monitor: FSM states, halt causes, SYSTEM opcodes.
// No logic of its own; no latency and no backpressure.
package rv32i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALT    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_ECALL  = 2'd1,
    CAUSE_EBREAK = 2'd2
  } halt_cause_t;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  function automatic logic is_halt_instr(input logic [31:0] instr);
    return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, increment 0..2 per cycle.
// One-cycle latency from inc to count; no backpressure, sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [1:0]       inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, count} + {{(WIDTH-1){1'b0}}, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (sum[WIDTH]) begin
      count <= '1;
    end else begin
      count <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pipeline_monitor.sv
// Dual-issue execute-stage run monitor: counts cycles/retires/redirects, stops on ECALL/EBREAK or timeout.
// Outputs registered (one edge after the RUN cycle); never stalls the pipe. PIPELINE_MONITOR_STALL_STATS_EN adds stall/bubble counters.
module pipeline_monitor
  import rv32i_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic             ex0_valid,
  input  logic             ex1_valid,
  input  logic [31:0]      ex0_instr,
  input  logic [31:0]      ex1_instr,
  input  logic             redirect0,
  input  logic             redirect1,
  input  logic             stall,
  input  logic             bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
`ifdef PIPELINE_MONITOR_STALL_STATS_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
`endif
  output logic             halted,
  output logic             timed_out,
  output logic             done,
  output logic [1:0]       halt_cause,
  output logic             halt_slot
);

  mon_state_t  state_q, state_d;
  halt_cause_t cause_q;
  logic [CNT_W-1:0] max_q;
  logic run, arm, halt0, halt1, any_halt, slot1_live, timeout_hit;
  logic [1:0] cyc_inc, ret_inc, redir_inc;

  assign run  = (state_q == ST_RUN);
  assign arm  = (state_q == ST_IDLE) && start;

  // An older-slot halt squashes slot 1 entirely (retire and redirect).
  assign halt0      = ex0_valid && is_halt_instr(ex0_instr);
  assign halt1      = ex1_valid && is_halt_instr(ex1_instr);
  assign any_halt   = halt0 || halt1;
  assign slot1_live = ex1_valid && !halt0;

  assign timeout_hit = (max_q != '0) &&
                       ((cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1}) == max_q);

  assign cyc_inc   = {1'b0, run};
  assign ret_inc   = run ? ({1'b0, ex0_valid} + {1'b0, slot1_live}) : 2'd0;
  assign redir_inc = run ? ({1'b0, ex0_valid && redirect0} +
                            {1'b0, slot1_live && redirect1}) : 2'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (any_halt)         state_d = ST_HALT;
        else if (timeout_hit) state_d = ST_TIMEOUT;
      end
      ST_HALT,
      ST_TIMEOUT: if (clear) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q     <= '0;
      halted    <= 1'b0;
      timed_out <= 1'b0;
      done      <= 1'b0;
      cause_q   <= CAUSE_NONE;
      halt_slot <= 1'b0;
    end else if (arm) begin
      max_q     <= max_cycles;
      halted    <= 1'b0;
      timed_out <= 1'b0;
      done      <= 1'b0;
      cause_q   <= CAUSE_NONE;
      halt_slot <= 1'b0;
    end else begin
      done <= run && (any_halt || timeout_hit);
      if (run && any_halt) begin
        halted    <= 1'b1;
        halt_slot <= !halt0;
        cause_q   <= ((halt0 ? ex0_instr : ex1_instr) == INSTR_EBREAK) ?
                     CAUSE_EBREAK : CAUSE_ECALL;
      end else if (run && timeout_hit) begin
        timed_out <= 1'b1;
      end
    end
  end

  assign state      = state_q;
  assign halt_cause = cause_q;

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst_n(rst_n), .clr(arm), .inc(cyc_inc), .count(cycle_cnt));
  sat_counter #(.WIDTH(CNT_W)) u_retired_cnt (
    .clk(clk), .rst_n(rst_n), .clr(arm), .inc(ret_inc), .count(retired_cnt));
  sat_counter #(.WIDTH(CNT_W)) u_redirect_cnt (
    .clk(clk), .rst_n(rst_n), .clr(arm), .inc(redir_inc), .count(redirect_cnt));

`ifdef PIPELINE_MONITOR_STALL_STATS_EN
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(arm), .inc({1'b0, run && stall}), .count(stall_cnt));
  sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst_n(rst_n), .clr(arm), .inc({1'b0, run && bubble}), .count(bubble_cnt));
`else
  logic unused_stats;
  assign unused_stats = stall ^ bubble;
`endif

endmodule
